uart_loader: RTL

Serial program loader between the UART receive path and the instruction/data RAM write port. It accepts a framed byte stream and assembles little-endian 32-bit words. It writes them to consecutive RAM word addresses starting at 0 and holds the CPU in reset while a load is in progress. It sits upstream of the RAM write mux and of the CPU reset input.

---
 rtl/loader_pkg.sv | 18 +
 rtl/uart_loader_if.sv | 24 ++
 rtl/loader_timeout.sv | 27 ++
 rtl/uart_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: FSM encoding, default frame marker, checksum width.
package loader_pkg;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int         CSUM_W        = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/uart_loader_if.sv
// Byte-stream input (valid/ready) plus RAM write port and CPU control outputs of the loader.
interface uart_loader_if #(
    parameter int ADDR_W = 13
);
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [31:0]       o_wr_data;
    logic              o_wr_en;
    logic              o_cpu_hold;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_rx_ready, o_wr_addr, o_wr_data, o_wr_en, o_cpu_hold, o_done, o_err
    );

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_rx_ready, o_wr_addr, o_wr_data, o_wr_en, o_cpu_hold, o_done, o_err
    );
endinterface

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reloads on i_load or while not running, counts down otherwise.
// o_expired is a combinational pulse when the count reaches zero while running.
module loader_timeout #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);
    localparam int              CNT_W    = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load || !i_run) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = i_run && !i_load && (r_cnt == '0);

endmodule

// File: rtl/uart_loader.sv
// Framed byte stream -> little-endian 32-bit RAM words at consecutive addresses; CPU held while busy.
// Write strobe one cycle after a word's 4th byte; o_rx_ready drops only during that write cycle.
module uart_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 13,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int         TIMEOUT   = 1_000_000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_loader_if.slave  bus
);
    state_t              r_state;
    state_t              w_state_next;
    logic                w_rx_ready;
    logic                w_accept;
    logic                w_expired;
    logic                w_is_sync;
    logic                w_len_too_big;
    logic                w_last_word;
    logic [15:0]         w_len;
    logic [CSUM_W-1:0]   w_csum_total;

    logic [7:0]          r_len_lo;
    logic [15:0]         r_len;
    logic [1:0]          r_idx;
    logic [ADDR_W:0]     r_words;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_word;
    logic [CSUM_W-1:0]   r_sum;
    logic                r_wr_en;
    logic                r_hold;
    logic                r_done;
    logic                r_err;

    assign w_accept      = bus.i_rx_valid && w_rx_ready;
    assign w_is_sync     = (bus.i_rx_data == SYNC_BYTE);
    assign w_len         = {bus.i_rx_data, r_len_lo};
    assign w_len_too_big = ({16'd0, w_len} > (32'd1 << ADDR_W));
    // Word counter is one bit wider than the address so a full 2^ADDR_W image terminates.
    assign w_last_word   = ((32'(r_words) + 32'd1) == {16'd0, r_len});
    assign w_csum_total  = r_sum + bus.i_rx_data;

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_accept),
        .i_run     (r_state != S_IDLE),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rx_ready   = (r_state != S_WRITE);
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_sync) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept)       w_state_next = S_LEN_HI;
                else if (w_expired) w_state_next = S_ERR;
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if (w_len_too_big)    w_state_next = S_ERR;
                    else if (w_len == '0) w_state_next = S_CSUM;
                    else                  w_state_next = S_DATA;
                end else if (w_expired) begin
                    w_state_next = S_ERR;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (r_idx == 2'd3) w_state_next = S_WRITE;
                end else if (w_expired) begin
                    w_state_next = S_ERR;
                end
            end
            S_WRITE: begin
                w_state_next = w_last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (w_accept)       w_state_next = (w_csum_total == '0) ? S_DONE : S_ERR;
                else if (w_expired) w_state_next = S_ERR;
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len_lo <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_words  <= '0;
            r_addr   <= '0;
            r_word   <= '0;
            r_sum    <= '0;
            r_wr_en  <= 1'b0;
            r_hold   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // Status flags are registered from the next state so they line up with it.
            r_wr_en <= (w_state_next == S_WRITE);
            r_done  <= (w_state_next == S_DONE);
            r_hold  <= (w_state_next != S_IDLE);

            if (r_state == S_IDLE && w_accept && w_is_sync) begin
                r_err <= 1'b0;
            end else if (w_state_next == S_ERR) begin
                r_err <= 1'b1;
            end

            if (r_state == S_WRITE) begin
                r_addr  <= r_addr + 1'b1;
                r_words <= r_words + 1'b1;
            end

            if (w_accept) begin
                case (r_state)
                    S_LEN_LO: r_len_lo <= bus.i_rx_data;
                    S_LEN_HI: begin
                        r_len   <= w_len;
                        r_addr  <= '0;
                        r_words <= '0;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                    S_DATA: begin
                        r_word[8*r_idx +: 8] <= bus.i_rx_data;
                        r_idx                <= r_idx + 1'b1;
                        r_sum                <= r_sum + bus.i_rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_rx_ready = w_rx_ready;
    assign bus.o_wr_addr  = r_addr;
    assign bus.o_wr_data  = r_word;
    assign bus.o_wr_en    = r_wr_en;
    assign bus.o_cpu_hold = r_hold;
    assign bus.o_done     = r_done;
    assign bus.o_err      = r_err;

endmodule
